// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, functs,
// ALU control codes and the control FSM state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_PASS = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1111;

  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_MEM_ADR = 4'd2;
  localparam logic [3:0] ST_MEM_RD  = 4'd3;
  localparam logic [3:0] ST_MEM_WB  = 4'd4;
  localparam logic [3:0] ST_MEM_WR  = 4'd5;
  localparam logic [3:0] ST_EXEC    = 4'd6;
  localparam logic [3:0] ST_ALU_WB  = 4'd7;
  localparam logic [3:0] ST_BRANCH  = 4'd8;
  localparam logic [3:0] ST_JUMP    = 4'd9;
  localparam logic [3:0] ST_ADDI_EX = 4'd10;
  localparam logic [3:0] ST_ADDI_WB = 4'd11;
  localparam logic [3:0] ST_JR      = 4'd12;

endpackage

// File: rtl/alu_ctrl_decode.sv
// R-type funct decoder: maps funct to the ALU control code and flags jr and
// unsupported functs.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_control,
  output logic       o_is_jr,
  output logic       o_legal
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_is_jr       = 1'b0;
    o_legal       = 1'b1;
    case (i_funct)
      FN_ADD: o_alu_control = ALU_ADD;
      FN_SUB: o_alu_control = ALU_SUB;
      FN_AND: o_alu_control = ALU_AND;
      FN_OR:  o_alu_control = ALU_OR;
      FN_SLT: o_alu_control = ALU_SLT;
      FN_SLL: o_alu_control = ALU_SLL;
      FN_JR: begin
        o_alu_control = ALU_PASS;
        o_is_jr       = 1'b1;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode,
// execute, memory and writeback, and counts retired instructions.
module mc_control_fsm
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_control,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired,
  output logic [3:0]       dbg_state
);

  // Memory handshake: mem_req stays high in FETCH/MEM_RD/MEM_WR until the
  // cycle mem_ready is seen; that cycle completes the access and the FSM
  // advances on the following clock edge. mem_ready is ignored elsewhere.

  logic [3:0]       r_state;
  logic [3:0]       w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       w_fn_alu;
  logic             w_fn_is_jr;
  logic             w_fn_legal;
  logic             w_retire;

  alu_ctrl_decode u_alu_ctrl_decode (
    .i_funct       (funct),
    .o_alu_control (w_fn_alu),
    .o_is_jr       (w_fn_is_jr),
    .o_legal       (w_fn_legal)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH:   if (mem_ready) w_next_state = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (!w_fn_legal)     w_next_state = ST_FETCH;
            else if (w_fn_is_jr) w_next_state = ST_JR;
            else                 w_next_state = ST_EXEC;
          end
          OP_LW, OP_SW: w_next_state = ST_MEM_ADR;
          OP_BEQ:       w_next_state = ST_BRANCH;
          OP_J:         w_next_state = ST_JUMP;
          OP_ADDI:      w_next_state = ST_ADDI_EX;
          default:      w_next_state = ST_FETCH;
        endcase
      end
      // IR is stable until the next FETCH, so opcode still selects lw vs sw here.
      ST_MEM_ADR: w_next_state = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:  if (mem_ready) w_next_state = ST_MEM_WB;
      ST_MEM_WR:  if (mem_ready) w_next_state = ST_FETCH;
      ST_EXEC:    w_next_state = ST_ALU_WB;
      ST_ADDI_EX: w_next_state = ST_ADDI_WB;
      default:    w_next_state = ST_FETCH;
    endcase
  end

  always_comb begin
    case (r_state)
      ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JUMP, ST_JR, ST_ADDI_WB: w_retire = 1'b1;
      ST_MEM_WR: w_retire = mem_ready;
      default:   w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_source   = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal_op  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:                              illegal_op = !w_fn_legal;
          OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI:   illegal_op = 1'b0;
          default:                               illegal_op = 1'b1;
        endcase
      end
      ST_MEM_ADR, ST_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = w_fn_alu;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_source   = 2'b01;
        pc_en       = zero;
      end
      ST_JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
      end
      ST_JR: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_PASS;
        pc_en       = 1'b1;
      end
      ST_ADDI_WB: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign instr_retired = r_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: each instruction is expanded into its
// expected step list and per-step control word, compared cycle by cycle.
module tb_mc_control_fsm;

  localparam int CW = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
  } ctl_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode, funct;
  logic          zero, mem_ready;
  logic          mem_req, mem_write, i_or_d, ir_write, pc_en;
  logic [1:0]    pc_source, alu_src_b;
  logic          alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [3:0]    alu_control, dbg_state;
  logic [CW-1:0] instr_retired;

  int            vectors = 0;
  int            miscompares = 0;
  logic [CW-1:0] exp_cnt;
  logic [CW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .instr_retired(instr_retired), .dbg_state(dbg_state)
  );

  function automatic ctl_t got_ctl();
    return '{mem_req, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
             alu_src_b, alu_control, reg_write, reg_dst, mem_to_reg, illegal_op};
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b000000: return 4'b1111;
      6'b001000: return 4'b1000;
      default:   return 4'bxxxx;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                   6'b101010, 6'b000000, 6'b001000};
      6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Control word the specification lists for each step of an instruction.
  function automatic ctl_t ctl_for(input string step, input bit rdy, input bit z,
                                   input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    c.alu_control = 4'b0010;
    case (step)
      "FETCH":   begin c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_en = rdy; end
      "DECODE":  begin c.alu_src_b = 2'b11; c.illegal_op = !is_legal(op, fn); end
      "MEM_ADR", "ADDI_EX": begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      "MEM_RD":  begin c.mem_req = 1; c.i_or_d = 1; end
      "MEM_WB":  begin c.reg_write = 1; c.mem_to_reg = 1; end
      "MEM_WR":  begin c.mem_req = 1; c.mem_write = 1; c.i_or_d = 1; end
      "EXEC":    begin c.alu_src_a = 1; c.alu_control = alu_of(fn); end
      "ALU_WB":  begin c.reg_write = 1; c.reg_dst = 1; end
      "BRANCH":  begin c.alu_src_a = 1; c.alu_control = 4'b0110; c.pc_source = 2'b01; c.pc_en = z; end
      "JUMP":    begin c.pc_source = 2'b10; c.pc_en = 1; end
      "JR":      begin c.alu_src_a = 1; c.alu_control = 4'b1000; c.pc_en = 1; end
      "ADDI_WB": c.reg_write = 1;
      default:   c = 'x;
    endcase
    return c;
  endfunction

  task automatic do_cycle(input string step, input bit rdy, input bit z);
    ctl_t exp_c, got_c;
    mem_ready = rdy;
    zero      = z;
    @(negedge clk);
    exp_c = ctl_for(step, rdy, z, opcode, funct);
    got_c = got_ctl();
    vectors++;
    if (got_c !== exp_c) begin
      miscompares++;
      $display("FAIL ctl %s op=%b fn=%b rdy=%0d z=%0d state=%0d: got %h expected %h",
               step, opcode, funct, rdy, z, dbg_state, got_c, exp_c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string name);
    logic [CW-1:0] e;
    e = exp_q.pop_front();
    vectors++;
    if (instr_retired !== e) begin
      miscompares++;
      $display("FAIL %s: instr_retired got %0d expected %0d", name, instr_retired, e);
    end
  endtask

  // Waits < 0 pick a random 0..3 not-ready cycles before each memory completion.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fetch_wait, input int mem_wait, input bit bz);
    string steps[$];
    int    nw;
    opcode = op;
    funct  = fn;
    steps  = '{"FETCH", "DECODE"};
    if (is_legal(op, fn)) begin
      case (op)
        6'b100011: steps = {steps, "MEM_ADR", "MEM_RD", "MEM_WB"};
        6'b101011: steps = {steps, "MEM_ADR", "MEM_WR"};
        6'b000100: steps.push_back("BRANCH");
        6'b000010: steps.push_back("JUMP");
        6'b001000: steps = {steps, "ADDI_EX", "ADDI_WB"};
        default:   if (fn == 6'b001000) steps.push_back("JR");
                   else steps = {steps, "EXEC", "ALU_WB"};
      endcase
      exp_cnt = exp_cnt + 1'b1;
    end
    foreach (steps[i]) begin
      if (steps[i] inside {"FETCH", "MEM_RD", "MEM_WR"}) begin
        nw = (steps[i] == "FETCH") ? fetch_wait : mem_wait;
        if (nw < 0) nw = $urandom_range(0, 3);
        for (int k = 0; k < nw; k++) do_cycle(steps[i], 1'b0, 1'($urandom_range(0, 1)));
        do_cycle(steps[i], 1'b1, 1'($urandom_range(0, 1)));
      end else if (steps[i] == "BRANCH") begin
        do_cycle(steps[i], 1'($urandom_range(0, 1)), bz);
      end else begin
        do_cycle(steps[i], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    exp_q.push_back(exp_cnt);
    check_count($sformatf("retire op=%b fn=%b", op, fn));
  endtask

  task automatic test_reset();
    ctl_t exp_c;
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    exp_c = ctl_for("FETCH", 1'b0, 1'b0, 6'b0, 6'b0);
    vectors++;
    if (got_ctl() !== exp_c || instr_retired !== '0) begin
      miscompares++;
      $display("FAIL reset: ctl %h cnt %0d expected %h cnt 0", got_ctl(), instr_retired, exp_c);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    run_instr(6'b100011, 6'b000000, 0, 0, 1'b0);
  endtask

  task automatic test_r_alu();
    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);
    run_instr(6'b000000, 6'b000000, 0, 0, 1'b0);
    run_instr(6'b000000, 6'b101010, -1, -1, 1'b0);
  endtask

  task automatic test_fetch_wait();
    run_instr(6'b000010, 6'b000000, 3, 0, 1'b0);
    run_instr(6'b101011, 6'b000000, 0, 3, 1'b0);
  endtask

  task automatic test_branch();
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b1);
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b0);
  endtask

  task automatic test_illegal_jr();
    run_instr(6'b111111, 6'b000000, 0, 0, 1'b0);
    run_instr(6'b000000, 6'b111111, 0, 0, 1'b0);
    run_instr(6'b000000, 6'b001000, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] ops[8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                           6'b000010, 6'b001000, 6'b111111, 6'b000001};
    logic [5:0] fns[9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b101010, 6'b000000, 6'b001000, 6'b100001, 6'b111111};
    for (int n = 0; n < 150; n++)
      run_instr(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 8)], -1, -1,
                1'($urandom_range(0, 1)));
  endtask

  task automatic test_wrap();
    while (exp_cnt != {CW{1'b1}}) run_instr(6'b001000, 6'b000000, -1, -1, 1'b0);
    run_instr(6'b000010, 6'b000000, 0, 0, 1'b0);
    vectors++;
    if (instr_retired !== '0) begin
      miscompares++;
      $display("FAIL wrap: instr_retired got %0d expected 0", instr_retired);
    end
  endtask

  task automatic test_reset_mid_write();
    ctl_t exp_c;
    if (exp_cnt == '0) run_instr(6'b000010, 6'b000000, 0, 0, 1'b0);
    opcode = 6'b101011; funct = 6'b000000;
    do_cycle("FETCH", 1'b1, 1'b0);
    do_cycle("DECODE", 1'b0, 1'b0);
    do_cycle("MEM_ADR", 1'b0, 1'b0);
    mem_ready = 1'b0;
    @(negedge clk);
    exp_c = ctl_for("MEM_WR", 1'b0, 1'b0, opcode, funct);
    vectors++;
    if (got_ctl() !== exp_c) begin
      miscompares++;
      $display("FAIL mid_write pending: ctl %h expected %h", got_ctl(), exp_c);
    end
    #1 rst_n = 1'b0;
    #1;
    exp_c = ctl_for("FETCH", 1'b0, 1'b0, opcode, funct);
    vectors++;
    if (got_ctl() !== exp_c || instr_retired !== '0) begin
      miscompares++;
      $display("FAIL mid_write reset: ctl %h cnt %0d expected %h cnt 0",
               got_ctl(), instr_retired, exp_c);
    end
    @(posedge clk); #1;
    rst_n   = 1'b1;
    exp_cnt = '0;
    exp_q.delete();
    run_instr(6'b100011, 6'b000000, -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_r_alu();
    test_fetch_wait();
    test_branch();
    test_illegal_jr();
    test_random();
    test_wrap();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
